vector_reduce_pipe: RTL and testbench
=====================================

Name: vector_reduce_pipe

Overview:
- Pipelined adder-tree reduction of a packed vector of `vector_length` elements to one sum, followed by a frame accumulator.
- Accumulates the tree results of consecutive input beats until `in_last`, then emits one widened sum per frame.
- Valid/ready handshake on both sides with full backpressure; signed or unsigned arithmetic; any `vector_length`, including odd lengths and 1.
- Sits behind vector producers (dot-product / filter datapaths) as the generic reduce stage.

Parameters:
- vector_length, 7, number of elements per input beat (>=1).
- data_width, 48, width of each element.
- acc_guard_bits, 8, extra accumulator bits for frame growth.
- is_signed, 1, 1 = two's-complement operands, 0 = unsigned.
- Derived: num_stages = max(1, clog2(vector_length)); sum_width = data_width + clog2(vector_length) + acc_guard_bits.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_last  in  1  beat is last of frame.
- vector_in  in  vector_length*data_width  element i at bits [(i+1)*data_width-1 : i*data_width].
- out_valid  out  1  out_sum valid.
- out_ready  in  1  consumer accepts.
- out_sum  out  sum_width  frame sum.
- busy  out  1  any stage valid or frame partially accumulated.

Behaviour:
- Reset (synchronous, active-high): all stage valids=0, acc=0, acc_active=0, out_valid=0, out_sum=0, busy=0. in_ready=1 in the cycle after reset deasserts. Reset mid-frame discards all partial data; no output results.
- Advance enable: adv = !(out_valid && !out_ready). in_ready = adv; it is combinational from out_valid/out_ready. All pipeline registers (tree stages, accumulator, output) update only when adv=1; when adv=0 everything holds.
- Input accepted when in_valid && in_ready.
- Each element is extended to sum_width at entry: sign-extended if is_signed=1, else zero-extended.
- Tree stage k pairs adjacent operands of stage k-1: out[j] = in[2j] + in[2j+1]. With an odd operand count, the last operand passes through registered unchanged. Every stage is registered and carries a valid bit and a last bit.
- vector_length=1: one register stage, pass-through.
- Tree latency is num_stages cycles (with adv=1 throughout). The tree result reaches the accumulator at cycle num_stages after acceptance.
- Accumulator, on a valid tree result with adv=1:
  - acc_next = (acc_active ? acc : 0) + result.
  - If the beat's last=0: acc <= acc_next, acc_active <= 1.
  - If last=1: out_sum <= acc_next, out_valid <= 1, acc <= 0, acc_active <= 0.
- Input-to-output latency for a single-beat frame: num_stages+1 cycles (7 elements → 4 cycles).
- Output handshake:
  - out_valid holds, and out_sum is stable, until out_valid && out_ready.
  - If a new frame completes in the same cycle out_ready=1, out_sum is replaced and out_valid stays 1.
  - Otherwise out_valid clears on the handshake.
- Arithmetic wraps modulo 2^sum_width. No saturation, no overflow flag.
- Throughput is one beat per cycle with no bubbles while out_ready=1.
- busy = OR of all stage valids, acc_active, and out_valid.

Test Plan:
- Defaults, unsigned (is_signed=0), single beat elements 1..7, last=1, out_ready=1 → out_valid at cycle 4 after acceptance, out_sum=28, one cycle wide.
- Signed, elements {-1,-2,-3,4,5,6,-9}, last=1 → out_sum = -0 = 0. Separately {-5,0,0,0,0,0,0} → out_sum all-ones-minus-4 (-5 in sum_width bits).
- Frame of 3 back-to-back beats, all elements 2, in_last on the third → exactly one output, 42, at cycle 6 after the first acceptance; no output for beats 1–2.
- Backpressure: out_ready=0 with one result pending, streaming 5 frames → in_ready drops in the cycle out_valid=1; no beat lost or duplicated. After out_ready=1, sums appear in order.
- Reset asserted mid-frame after 2 non-last beats, then a 1-beat frame of 1s → out_sum=7 (old partial discarded); out_valid=0 and busy=0 during reset.
- vector_length=1 and vector_length=8 builds, data_width=16 → latency 2 and 4 respectively. Max unsigned operands over 256 beats → correct sum_width result with no truncation.

Source files
------------

// File: rtl/vector_reduce_pipe.sv
// vector_reduce_pipe: pipelined adder-tree vector reduction feeding a per-frame accumulator
module vector_reduce_pipe #(
  parameter int vector_length = 7,
  parameter int data_width = 48,
  parameter int acc_guard_bits = 8,
  parameter bit is_signed = 1'b1,
  localparam int num_stages = vector_length > 1 ? $clog2(vector_length) : 1,
  localparam int sum_width = data_width + $clog2(vector_length) + acc_guard_bits
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic                                  in_last,
  input  logic [vector_length*data_width-1:0]   vector_in,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [sum_width-1:0]                  out_sum,
  output logic                                  busy
);
  function automatic int stage_len(int k);
    int n = vector_length;
    for (int i = 0; i < k; i++) n = (n + 1) / 2;
    return n;
  endfunction
  logic adv;
  logic [num_stages:1] stage_busy;
  logic [sum_width-1:0] acc_q, acc_d, acc_next, out_sum_q, out_sum_d, res;
  logic acc_active_q, acc_active_d, out_valid_q, out_valid_d, res_valid, res_last;
  assign adv = !(out_valid_q && !out_ready);
  assign in_ready = adv;
  for (genvar k = 0; k <= num_stages; k++) begin : g_st
    localparam int n = stage_len(k);
    logic [sum_width-1:0] op [n];
    logic op_valid, op_last;
    if (k == 0) begin : g_in
      for (genvar j = 0; j < n; j++) begin : g_e
        if (is_signed) begin : g_s
          assign op[j] = sum_width'($signed(vector_in[j*data_width +: data_width]));
        end else begin : g_u
          assign op[j] = sum_width'(vector_in[j*data_width +: data_width]);
        end
      end
      assign op_valid = in_valid && adv;
      assign op_last = in_last;
    end else begin : g_tree
      localparam int m = stage_len(k - 1);
      logic [sum_width-1:0] sum_d [n];
      logic [sum_width-1:0] sum_q [n];
      logic valid_q, last_q;
      for (genvar j = 0; j < n; j++) begin : g_p
        if (2 * j + 1 < m) begin : g_add
          assign sum_d[j] = g_st[k-1].op[2*j] + g_st[k-1].op[2*j+1];
        end else begin : g_pass
          assign sum_d[j] = g_st[k-1].op[2*j];
        end
      end
      // tree stage register; the whole pipeline stalls together when the output is blocked
      always_ff @(posedge clk)
        if (reset) begin
          valid_q <= 1'b0;
          last_q <= 1'b0;
        end else if (adv) begin
          valid_q <= g_st[k-1].op_valid;
          last_q <= g_st[k-1].op_last;
          sum_q <= sum_d;
        end
      assign op = sum_q;
      assign op_valid = valid_q;
      assign op_last = last_q;
      assign stage_busy[k] = valid_q;
    end
  end
  assign res = g_st[num_stages].op[0];
  assign res_valid = g_st[num_stages].op_valid;
  assign res_last = g_st[num_stages].op_last;
  // fold tree results into the running frame sum; the last beat publishes it and restarts
  always_comb begin
    acc_next = (acc_active_q ? acc_q : '0) + res;
    acc_d = res_valid ? (res_last ? '0 : acc_next) : acc_q;
    acc_active_d = res_valid ? !res_last : acc_active_q;
    out_sum_d = res_valid && res_last ? acc_next : out_sum_q;
    out_valid_d = (res_valid && res_last) || (out_valid_q && !out_ready);
  end
  // accumulator and output registers
  always_ff @(posedge clk)
    if (reset) begin
      acc_q <= '0;
      acc_active_q <= 1'b0;
      out_sum_q <= '0;
      out_valid_q <= 1'b0;
    end else if (adv) begin
      acc_q <= acc_d;
      acc_active_q <= acc_active_d;
      out_sum_q <= out_sum_d;
      out_valid_q <= out_valid_d;
    end
  assign out_valid = out_valid_q;
  assign out_sum = out_sum_q;
  assign busy = |stage_busy || acc_active_q || out_valid_q;
endmodule

// File: tb/tb_vector_reduce_pipe.sv
// tb_vector_reduce_pipe: vector table, corner sequences and random scoreboard for vector_reduce_pipe
module tb_vector_reduce_pipe;
  localparam int L = 7;
  localparam int DW = 48;
  localparam int SW = 59;
  typedef struct {
    logic [L*DW-1:0] v;
    logic [SW-1:0] exp;
  } vec_t;
  logic clk, reset, in_valid, in_last, out_ready;
  logic [L*DW-1:0] vec;
  logic in_ready, out_valid, busy;
  logic [SW-1:0] out_sum;
  logic [8*16-1:0] vec8;
  logic r8, v8, b8;
  logic [26:0] s8;
  logic [15:0] vec1;
  logic r1, v1, b1;
  logic [23:0] s1;
  int checks = 0, errors = 0;
  bit sb_en = 0, hold_pend = 0, saw_stall = 0;
  logic [SW-1:0] hold_sum;
  logic [SW-1:0] exp_q [$];
  longint part = 0;
  int pops = 0, accs = 0;

  vector_reduce_pipe dut (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .vector_in(vec), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .busy(busy));
  vector_reduce_pipe #(.vector_length(8), .data_width(16), .acc_guard_bits(8), .is_signed(1'b0)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r8), .in_last(in_last),
    .vector_in(vec8), .out_valid(v8), .out_ready(out_ready), .out_sum(s8), .busy(b8));
  vector_reduce_pipe #(.vector_length(1), .data_width(16), .acc_guard_bits(8), .is_signed(1'b0)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r1), .in_last(in_last),
    .vector_in(vec1), .out_valid(v1), .out_ready(out_ready), .out_sum(s1), .busy(b1));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [L*DW-1:0] pack(longint e[7]);
    logic [L*DW-1:0] r;
    for (int j = 0; j < L; j++) r[j*DW +: DW] = e[j][DW-1:0];
    return r;
  endfunction

  function automatic longint beat_sum(logic [L*DW-1:0] v);
    longint s = 0;
    for (int j = 0; j < L; j++) s += longint'($signed(v[j*DW +: DW]));
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    if (sb_en) begin
      chk("in_ready_rule", {63'd0, in_ready}, {63'd0, !(out_valid && !out_ready)});
      if (!in_ready) saw_stall = 1;
      if (hold_pend) chk("hold", {4'd0, out_valid, out_sum}, {4'd0, 1'b1, hold_sum});
      hold_pend = out_valid && !out_ready;
      hold_sum = out_sum;
      if (out_valid && out_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra: got %0h expected no output", out_sum);
        end else chk("sb_sum", {5'd0, out_sum}, {5'd0, exp_q.pop_front()});
      end
      if (in_valid && in_ready) begin
        accs++;
        part += beat_sum(vec);
        if (in_last) begin
          exp_q.push_back(SW'(part));
          part = 0;
        end
      end
    end
    tick();
  endtask

  task automatic rand_vec();
    for (int j = 0; j < L; j++) vec[j*DW +: DW] = 48'({$urandom(), $urandom()});
  endtask

  initial begin
    vec_t tbl [7];
    longint mx, mn;
    int lat, lm, l8, l1, n;
    bit got, gm, g8, g1;
    logic [SW-1:0] sum;
    logic [26:0] sum8;
    logic [23:0] sum1;
    mx = (64'sd1 <<< 47) - 1;
    mn = -(64'sd1 <<< 47);
    tbl[0] = '{pack('{1, 2, 3, 4, 5, 6, 7}), SW'(28)};
    tbl[1] = '{pack('{-1, -2, -3, 4, 5, 6, -9}), SW'(0)};
    tbl[2] = '{pack('{-5, 0, 0, 0, 0, 0, 0}), SW'(-5)};
    tbl[3] = '{pack('{mx, mx, mx, mx, mx, mx, mx}), SW'(7 * mx)};
    tbl[4] = '{pack('{mn, mn, mn, mn, mn, mn, mn}), SW'(7 * mn)};
    tbl[5] = '{pack('{0, 0, 0, 0, 0, 0, 100}), SW'(100)};
    tbl[6] = '{pack('{mx, mn, 0, 0, 0, 0, 0}), SW'(-1)};
    reset = 1; in_valid = 0; in_last = 0; out_ready = 1; vec = '0; vec8 = '0; vec1 = '0;
    tick();
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {61'd0, busy, b8, b1}, 64'd0);
    tick();
    reset = 0;
    @(negedge clk);
    chk("post_rst_ready", {61'd0, in_ready, r8, r1}, 64'd7);
    chk("post_rst_sum", {5'd0, out_sum}, 64'd0);
    tick();
    // single beat through all three builds: latency and sums
    for (int j = 0; j < 8; j++) vec8[j*16 +: 16] = 16'(j + 1);
    vec = tbl[0].v; vec1 = 16'd5; in_valid = 1; in_last = 1;
    step();
    in_valid = 0;
    lm = 0; l8 = 0; l1 = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (out_valid && lm == 0) begin lm = c; sum = out_sum; end
      if (v8 && l8 == 0) begin l8 = c; sum8 = s8; end
      if (v1 && l1 == 0) begin l1 = c; sum1 = s1; end
      tick();
    end
    chk("lat_l7", 64'(lm), 64'd4);
    chk("lat_l8", 64'(l8), 64'd4);
    chk("lat_l1", 64'(l1), 64'd2);
    chk("sum_l7", {5'd0, sum}, 64'd28);
    chk("sum_l8", {37'd0, sum8}, 64'd36);
    chk("sum_l1", {40'd0, sum1}, 64'd5);
    // 256 beats of maximum operands, one frame
    vec = pack('{mx, mx, mx, mx, mx, mx, mx}); vec8 = '1; vec1 = '1; in_valid = 1;
    for (int b = 0; b < 256; b++) begin
      in_last = (b == 255);
      step();
    end
    in_valid = 0; in_last = 0;
    gm = 0; g8 = 0; g1 = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid) begin gm = 1; sum = out_sum; end
      if (v8) begin g8 = 1; sum8 = s8; end
      if (v1) begin g1 = 1; sum1 = s1; end
      tick();
    end
    chk("max_seen", {61'd0, gm, g8, g1}, 64'd7);
    chk("max_l7", {5'd0, sum}, {5'd0, SW'(256 * 7 * mx)});
    chk("max_l8", {37'd0, sum8}, 64'd134215680);
    chk("max_l1", {40'd0, sum1}, 64'd16776960);
    chk("max_idle", {61'd0, busy, b8, b1}, 64'd0);
    // vector table, single-beat frames
    for (int i = 0; i < 7; i++) begin
      vec = tbl[i].v; in_valid = 1; in_last = 1;
      @(negedge clk);
      chk("tbl_accept", {63'd0, in_ready}, 64'd1);
      tick();
      in_valid = 0; lat = 1; got = 0;
      while (!got && lat < 12) begin
        @(negedge clk);
        if (out_valid) begin got = 1; sum = out_sum; end
        else begin tick(); lat++; end
      end
      chk("tbl_lat", 64'(lat), 64'd4);
      chk("tbl_sum", {5'd0, sum}, {5'd0, tbl[i].exp});
      tick();
      @(negedge clk);
      chk("tbl_pulse", {63'd0, out_valid}, 64'd0);
      tick();
    end
    // three-beat frame of 2s
    vec = pack('{2, 2, 2, 2, 2, 2, 2}); in_valid = 1; in_last = 0;
    step(); step();
    in_last = 1;
    step();
    in_valid = 0; in_last = 0; n = 0; lat = 0;
    for (int c = 3; c < 12; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (n == 0) begin lat = c; sum = out_sum; end
        n++;
      end
      tick();
    end
    chk("frame3_count", 64'(n), 64'd1);
    chk("frame3_lat", 64'(lat), 64'd6);
    chk("frame3_sum", {5'd0, sum}, 64'd42);
    // reset in the middle of a frame discards the partial sum
    vec = pack('{3, 3, 3, 3, 3, 3, 3}); in_valid = 1; in_last = 0;
    step(); step();
    in_valid = 0; reset = 1;
    tick();
    @(negedge clk);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    tick();
    reset = 0;
    vec = pack('{1, 1, 1, 1, 1, 1, 1}); in_valid = 1; in_last = 1;
    step();
    in_valid = 0; got = 0; lat = 0;
    while (!got && lat < 12) begin
      @(negedge clk);
      if (out_valid) begin got = 1; sum = out_sum; end
      tick();
      lat++;
    end
    chk("midrst_seen", {63'd0, got}, 64'd1);
    chk("midrst_sum", {5'd0, sum}, 64'd7);
    for (int c = 0; c < 6; c++) tick();
    // backpressure: five single-beat frames with the consumer stalled at first
    sb_en = 1; hold_pend = 0; part = 0; exp_q.delete(); pops = 0; accs = 0; saw_stall = 0;
    in_last = 1;
    for (int k = 0; k < 60; k++) begin
      out_ready = (k >= 12);
      in_valid = (accs < 5);
      rand_vec();
      step();
    end
    chk("bp_accepted", 64'(accs), 64'd5);
    chk("bp_outputs", 64'(pops), 64'd5);
    chk("bp_stalled", {63'd0, saw_stall}, 64'd1);
    // random traffic against the frame-sum model
    for (int k = 0; k < 1500; k++) begin
      in_valid = ($urandom_range(3) != 0);
      in_last = ($urandom_range(2) == 0);
      out_ready = ($urandom_range(3) != 0);
      rand_vec();
      if ($urandom_range(7) == 0) vec[$urandom_range(L-1)*DW +: DW] = 48'h7FFF_FFFF_FFFF;
      step();
    end
    in_valid = 1; in_last = 1; out_ready = 1;
    step();
    in_valid = 0;
    for (int k = 0; k < 10; k++) step();
    chk("rand_drained", 64'(exp_q.size()), 64'd0);
    chk("rand_idle", {63'd0, busy}, 64'd0);
    chk("rand_progress", 64'(pops > 50), 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
